// File: rtl/uart_alu_ctrl_if.sv
// rtl/uart_alu_ctrl_if.sv - handshake bundle between the UART/ALU sequencer and its RX, ALU and TX peers
interface uart_alu_ctrl_if #(
    parameter int OP_W = 6
);
    logic            i_rx_done;
    logic [7:0]      i_rx_data;
    logic [7:0]      i_alu_result;
    logic            i_tx_done;
    logic [7:0]      o_alu_a;
    logic [7:0]      o_alu_b;
    logic [OP_W-1:0] o_alu_op;
    logic [7:0]      o_tx_data;
    logic            o_tx_start;
    logic            o_busy;
    logic            o_timeout;
    logic            o_overrun;

    modport slave (
        input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
               o_busy, o_timeout, o_overrun
    );

    modport master (
        output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
               o_busy, o_timeout, o_overrun
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - collects A, B, opcode bytes, runs the ALU and launches one TX byte
// Optional opcode legality check enabled by defining ALU_OPCODE_CHECK_EN.
module uart_alu_ctrl #(
    parameter int OP_W           = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic           i_clock,
    input  logic           i_reset,
    uart_alu_ctrl_if.slave bus
);
    localparam logic [4:0] S_WAIT_A  = 5'b00001;
    localparam logic [4:0] S_WAIT_B  = 5'b00010;
    localparam logic [4:0] S_WAIT_OP = 5'b00100;
    localparam logic [4:0] S_EXEC    = 5'b01000;
    localparam logic [4:0] S_WAIT_TX = 5'b10000;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [4:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             exec_go;   // second EXEC cycle: ALU result is settled, launch TX
`ifdef ALU_OPCODE_CHECK_EN
    logic             bad_op;

    function automatic logic legal_op(input logic [OP_W-1:0] op);
        case (6'(op))
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b000011, 6'b000010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

    assign bus.o_busy = state[3] | state[4];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state          <= S_WAIT_A;
            cnt            <= '0;
            exec_go        <= 1'b0;
            bus.o_alu_a    <= '0;
            bus.o_alu_b    <= '0;
            bus.o_alu_op   <= '0;
            bus.o_tx_data  <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_timeout  <= 1'b0;
            bus.o_overrun  <= 1'b0;
`ifdef ALU_OPCODE_CHECK_EN
            bad_op         <= 1'b0;
`endif
        end else begin
            bus.o_tx_start <= 1'b0;
            bus.o_timeout  <= 1'b0;
            bus.o_overrun  <= 1'b0;
            case (state)
                S_WAIT_A: begin
                    cnt <= '0;
                    if (bus.i_rx_done) begin
                        bus.o_alu_a <= bus.i_rx_data;
                        state       <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (bus.i_rx_done) begin
                        bus.o_alu_b <= bus.i_rx_data;
                        cnt         <= '0;
                        state       <= S_WAIT_OP;
                    end else if (cnt == CNT_LAST) begin
                        cnt           <= '0;
                        bus.o_timeout <= 1'b1;
                        state         <= S_WAIT_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        cnt   <= '0;
                        state <= S_EXEC;
`ifdef ALU_OPCODE_CHECK_EN
                        // Illegal opcode skips the settle cycle and answers 8'hFF
                        if (legal_op(bus.i_rx_data[OP_W-1:0])) begin
                            bus.o_alu_op <= bus.i_rx_data[OP_W-1:0];
                            exec_go      <= 1'b0;
                            bad_op       <= 1'b0;
                        end else begin
                            exec_go      <= 1'b1;
                            bad_op       <= 1'b1;
                        end
`else
                        bus.o_alu_op <= bus.i_rx_data[OP_W-1:0];
                        exec_go      <= 1'b0;
`endif
                    end else if (cnt == CNT_LAST) begin
                        cnt           <= '0;
                        bus.o_timeout <= 1'b1;
                        state         <= S_WAIT_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (bus.i_rx_done)
                        bus.o_overrun <= 1'b1;
                    if (exec_go) begin
`ifdef ALU_OPCODE_CHECK_EN
                        bus.o_tx_data <= bad_op ? 8'hFF : bus.i_alu_result;
`else
                        bus.o_tx_data <= bus.i_alu_result;
`endif
                        bus.o_tx_start <= 1'b1;
                        exec_go        <= 1'b0;
                        state          <= S_WAIT_TX;
                    end else begin
                        exec_go <= 1'b1;
                    end
                end
                S_WAIT_TX: begin
                    if (bus.i_rx_done)
                        bus.o_overrun <= 1'b1;
                    if (bus.i_tx_done) begin
                        cnt   <= '0;
                        state <= S_WAIT_A;
                    end
                end
                default: begin
                    cnt     <= '0;
                    exec_go <= 1'b0;
                    state   <= S_WAIT_A;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - table, hand-sequence and randomized checks of uart_alu_ctrl
module tb_uart_alu_ctrl;
    localparam int OP_W = 6;
    localparam int T    = 16;

    logic i_clock = 1'b0;
    logic i_reset;
    int   checks = 0;
    int   errors = 0;

    always #5 i_clock = ~i_clock;

    uart_alu_ctrl_if #(.OP_W(OP_W)) bus ();

    uart_alu_ctrl #(.OP_W(OP_W), .TIMEOUT_CYCLES(T)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b000011: return 8'($signed(a) >>> b[2:0]);
            6'b000010: return a >> b[2:0];
            default:   return a ^ 8'h5A;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] op);
`ifdef ALU_OPCODE_CHECK_EN
        return op inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                          6'b100110, 6'b100111, 6'b000011, 6'b000010};
`else
        return (op == op);
`endif
    endfunction

    assign bus.i_alu_result = alu(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = d;
        step();
        bus.i_rx_done = 1'b0;
    endtask

    task automatic tx_ack();
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
    } vec_t;

    // Reference model: counts bytes of the frame and elapsed idle/exec cycles
    int         nb, idle, exec_left;
    bit         waiting, bad;
    logic [7:0] ma, mb, mtx;
    logic [5:0] mop;
    bit         mstart, mto, mov;

    task automatic model_reset();
        nb = 0; idle = 0; exec_left = 0; waiting = 0; bad = 0;
        ma = 0; mb = 0; mtx = 0; mop = 0; mstart = 0; mto = 0; mov = 0;
    endtask

    task automatic model_edge(input bit rx, input logic [7:0] d, input bit txd);
        mstart = 0; mto = 0; mov = 0;
        if (waiting) begin
            if (rx) mov = 1;
            if (txd) waiting = 0;
        end else if (exec_left > 0) begin
            if (rx) mov = 1;
            exec_left--;
            if (exec_left == 0) begin
                mtx = bad ? 8'hFF : alu(ma, mb, mop);
                mstart = 1;
                waiting = 1;
            end
        end else if (rx) begin
            idle = 0;
            if (nb == 0) ma = d;
            else if (nb == 1) mb = d;
            else begin
                bad = !legal(d[5:0]);
                if (!bad) mop = d[5:0];
                exec_left = bad ? 1 : 2;
            end
            nb = (nb == 2) ? 0 : nb + 1;
        end else if (nb > 0) begin
            if (idle == T - 1) begin
                mto = 1; nb = 0; idle = 0;
            end else begin
                idle++;
            end
        end
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{8'h05, 8'h03, 6'b100000, 8'h08};
        vecs[1] = '{8'h11, 8'h22, 6'b100010, 8'hEF};
        vecs[2] = '{8'hF0, 8'h3C, 6'b100100, 8'h30};
        vecs[3] = '{8'hF0, 8'h0F, 6'b100101, 8'hFF};
        vecs[4] = '{8'hAA, 8'hFF, 6'b100110, 8'h55};
        vecs[5] = '{8'h0F, 8'hF0, 6'b100111, 8'h00};
        vecs[6] = '{8'h80, 8'h02, 6'b000011, 8'hE0};
        vecs[7] = '{8'h80, 8'h03, 6'b000010, 8'h10};

        bus.i_rx_done = 0; bus.i_rx_data = 0; bus.i_tx_done = 0;
        do_reset();
        check("reset_outputs", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data,
              bus.o_tx_start, bus.o_busy, bus.o_timeout, bus.o_overrun}, 64'd0);

        // Table-driven frames with exact launch latency
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a); send(vecs[i].b); send({2'b00, vecs[i].op});
            check("operands", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op}, {vecs[i].a, vecs[i].b, vecs[i].op});
            check("busy_exec", bus.o_busy, 1);
            check("start_n", bus.o_tx_start, 0);
            step();
            check("start_n1", bus.o_tx_start, 0);
            step();
            check("start_n2", {bus.o_tx_start, bus.o_tx_data}, {1'b1, vecs[i].res});
            step();
            check("start_n3", {bus.o_tx_start, bus.o_busy}, 2'b01);
            tx_ack();
            check("idle_after_tx", bus.o_busy, 0);
        end

        // Timeout after a lone byte, then a normal frame
        do_reset();
        send(8'hAA);
        for (int i = 0; i < T - 1; i++) step();
        check("timeout_early", bus.o_timeout, 0);
        step();
        check("timeout_pulse", bus.o_timeout, 1);
        step();
        check("timeout_once", {bus.o_timeout, bus.o_alu_a}, {1'b0, 8'hAA});
        send(8'h11); send(8'h22); send(8'h22);
        step(); step();
        check("after_timeout_tx", {bus.o_tx_start, bus.o_tx_data}, {1'b1, 8'hEF});
        step(); tx_ack();

        // Overrun during WAIT_TX
        send(8'h01); send(8'h02); send(8'h20);
        step(); step(); step();
        send(8'h77);
        check("overrun_pulse", {bus.o_overrun, bus.o_alu_a, bus.o_busy}, {1'b1, 8'h01, 1'b1});
        step();
        check("overrun_once", bus.o_overrun, 0);
        tx_ack();
        check("overrun_tx_done", bus.o_busy, 0);

        // tx_done coinciding with the launch edge is ignored
        send(8'h03); send(8'h04); send(8'h20);
        step();
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
        check("txdone_on_launch", {bus.o_tx_start, bus.o_busy}, 2'b11);
        step();
        check("still_waiting", bus.o_busy, 1);
        tx_ack();
        check("released", bus.o_busy, 0);

        // Asynchronous reset between edges
        send(8'h33); send(8'h44);
        #2 i_reset = 1'b1;
        #1 check("async_reset", {bus.o_alu_a, bus.o_alu_b, bus.o_busy}, 17'd0);
        i_reset = 1'b0;
        send(8'h5A);
        check("load_after_reset", {bus.o_alu_a, bus.o_alu_b}, {8'h5A, 8'h00});

        // Byte on the exact expiry edge wins
        do_reset();
        send(8'hA1);
        for (int i = 0; i < T - 1; i++) step();
        send(8'hB2);
        check("expiry_byte_wins", {bus.o_alu_b, bus.o_timeout}, {8'hB2, 1'b0});
        send(8'h24); step(); step(); step(); tx_ack();

`ifdef ALU_OPCODE_CHECK_EN
        send(8'h01); send(8'h02); send(8'h3F);
        check("illegal_op_kept", bus.o_alu_op, 6'b100100);
        step();
        check("illegal_op_ff", {bus.o_tx_start, bus.o_tx_data}, {1'b1, 8'hFF});
        step(); tx_ack();
`endif

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit rx, txd;
            logic [7:0] d;
            rx  = ($urandom_range(0, 99) < ((c < 1500) ? 30 : 6));
            txd = ($urandom_range(0, 99) < 25);
            d   = 8'($urandom);
            bus.i_rx_done = rx; bus.i_rx_data = d; bus.i_tx_done = txd;
            model_edge(rx, d, txd);
            step();
            check("random", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data,
                  bus.o_tx_start, bus.o_timeout, bus.o_overrun, bus.o_busy},
                  {ma, mb, mop, mtx, mstart, mto, mov, (waiting || exec_left > 0)});
        end
        bus.i_rx_done = 0; bus.i_tx_done = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
